// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: S-box table, xtime, RCON seed,
// engine state enum and word-count helpers.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int NR_OF(input int nk);
    return nk + 6;
  endfunction

  function automatic int TOTAL_WORDS(input int nk);
    return 4 * (nk + 7);
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Key-schedule request/read bus; NK sets the key width in 32-bit words.
// Optional stream signals exist only with KSCHED_STREAM_EN defined.
interface aes_key_schedule_seq_if #(
  parameter int NK = 8
);
  logic [NK*32-1:0] key_in;
  logic             start;
  logic             busy;
  logic             done;
  logic             key_valid;
  logic [3:0]       rk_idx;
  logic [127:0]     round_key;
`ifdef KSCHED_STREAM_EN
  logic [127:0]     rk_out;
  logic             rk_out_valid;
  logic             rk_out_ready;
  logic [3:0]       rk_out_round;
`endif

  modport master (
    output key_in,
    output start,
    output rk_idx,
    input  busy,
    input  done,
    input  key_valid,
    input  round_key
`ifdef KSCHED_STREAM_EN
   ,input  rk_out,
    input  rk_out_valid,
    output rk_out_ready,
    input  rk_out_round
`endif
  );

  modport slave (
    input  key_in,
    input  start,
    input  rk_idx,
    output busy,
    output done,
    output key_valid,
    output round_key
`ifdef KSCHED_STREAM_EN
   ,output rk_out,
    output rk_out_valid,
    input  rk_out_ready,
    output rk_out_round
`endif
  );

endinterface

// File: rtl/aes_sub_word.sv
// AES SubWord: four parallel S-box lookups, purely combinational.
// Ports: din (32b word in), dout (substituted word out).
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  always_comb begin
    dout = {SBOX[din[31:24]], SBOX[din[23:16]],
            SBOX[din[15:8]],  SBOX[din[7:0]]};
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expansion, one schedule word per clock, with an
// indexed registered round-key read port for the decrypt datapath.
// Ports: clk, rst (async active-low), bus (slave modport):
//   key_in/start request, busy/done/key_valid status,
//   rk_idx -> round_key (1-cycle registered read).
// Option KSCHED_STREAM_EN: rk_out/rk_out_valid/rk_out_ready/rk_out_round
//   stream round keys Nr..0 after each expansion.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int Nk = 8,
  parameter int Nr = 14,
  parameter int Nb = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  aes_key_schedule_seq_if.slave bus
);

  localparam int TOTAL = Nb * (Nr + 1);
  localparam int IW    = 6;

  localparam logic [IW-1:0] LAST   = IW'(TOTAL - 1);
  localparam logic [IW-1:0] NKW    = IW'(Nk);
  localparam logic [2:0]    KC_MAX = 3'(Nk - 1);
  localparam logic [3:0]    NR4    = 4'(Nr);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_key_schedule_seq: Nk must be 4, 6 or 8");
  end
  if (Nr != NR_OF(Nk)) begin : g_bad_nr
    $error("aes_key_schedule_seq: Nr must equal Nk+6");
  end
  if (Nb != 4) begin : g_bad_nb
    $error("aes_key_schedule_seq: Nb must be 4");
  end

  ks_state_e     state;
  logic [IW-1:0] idx;
  logic [2:0]    kc;
  logic [7:0]    rcon;
  logic          busy_q;
  logic          done_q;
  logic          valid_q;
  logic [127:0]  rk_q;

  logic [31:0]   w [TOTAL];

  logic [31:0]   prev;
  logic [31:0]   back;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   nxt_word;
  logic          load;
  logic          restart;

  // start is honoured from IDLE and READY only
  assign load    = bus.start && (state != EXPAND);
  assign restart = bus.start && (state == READY);

  // kc tracks i mod Nk so Nk=6 needs no divider
  always_comb begin
    prev   = w[idx - IW'(1)];
    back   = w[idx - NKW];
    sub_in = (kc == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    temp   = prev;
    if (kc == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (Nk == 8 && kc == 3'd4)
      temp = sub_out;
    nxt_word = back ^ temp;
  end

  aes_sub_word u_sub (
    .din  (sub_in),
    .dout (sub_out)
  );

  // word store carries no reset; key_valid gates its use
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < Nk; k++)
        w[k] <= bus.key_in[Nk*32-1-32*k -: 32];
    end else if (state == EXPAND) begin
      w[idx] <= nxt_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      idx     <= '0;
      kc      <= '0;
      rcon    <= RCON_INIT;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, READY: begin
          if (bus.start) begin
            state   <= EXPAND;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            idx     <= NKW;
            kc      <= '0;
            rcon    <= RCON_INIT;
          end
        end
        EXPAND: begin
          idx <= idx + IW'(1);
          kc  <= (kc == KC_MAX) ? 3'd0 : kc + 3'd1;
          if (kc == 3'd0)
            rcon <= xtime(rcon);
          if (idx == LAST) begin
            state   <= READY;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [127:0] rk_at(input logic [3:0] r);
    return {w[{r, 2'b00}], w[{r, 2'b01}],
            w[{r, 2'b10}], w[{r, 2'b11}]};
  endfunction

  // a restart clears the read port on the same edge key_valid falls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rk_q <= '0;
    else if (!valid_q || restart || bus.rk_idx > NR4)
      rk_q <= '0;
    else
      rk_q <= rk_at(bus.rk_idx);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key_valid = valid_q;
  assign bus.round_key = rk_q;

`ifdef KSCHED_STREAM_EN
  logic [127:0] so_q;
  logic         so_v;
  logic [3:0]   so_r;

  // first key loads the cycle after done, once w[TOTAL-1] is stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      so_q <= '0;
      so_v <= 1'b0;
      so_r <= '0;
    end else if (restart || state != READY) begin
      so_v <= 1'b0;
    end else if (done_q) begin
      so_q <= rk_at(NR4);
      so_r <= NR4;
      so_v <= 1'b1;
    end else if (so_v && bus.rk_out_ready) begin
      if (so_r == 4'd0) begin
        so_v <= 1'b0;
      end else begin
        so_r <= so_r - 4'd1;
        so_q <= rk_at(so_r - 4'd1);
      end
    end
  end

  assign bus.rk_out       = so_q;
  assign bus.rk_out_valid = so_v;
  assign bus.rk_out_round = so_r;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq with Nk = 4, 6 and 8 instances.
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_seq_if #(.NK(4)) b4 ();
  aes_key_schedule_seq_if #(.NK(6)) b6 ();
  aes_key_schedule_seq_if #(.NK(8)) b8 ();

  aes_key_schedule_seq #(.Nk(4), .Nr(10), .Nb(4)) dut4 (
    .clk (clk), .rst (rst), .bus (b4));
  aes_key_schedule_seq #(.Nk(6), .Nr(12), .Nb(4)) dut6 (
    .clk (clk), .rst (rst), .bus (b6));
  aes_key_schedule_seq #(.Nk(8), .Nr(14), .Nb(4)) dut8 (
    .clk (clk), .rst (rst), .bus (b8));

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [127:0] K4A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K4C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K6  =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8  =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] R4A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R4A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R4C10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] R6_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R6_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] R8_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int d4, d6, d8, p4, p6, p8, e, xfers, exp_r;
  logic hold;
  logic [127:0] pd;
  logic [3:0] pr;

  initial begin
    b4.key_in = '0; b4.start = 0; b4.rk_idx = '0;
    b6.key_in = '0; b6.start = 0; b6.rk_idx = '0;
    b8.key_in = '0; b8.start = 0; b8.rk_idx = '0;
`ifdef KSCHED_STREAM_EN
    b4.rk_out_ready = 0;
    b6.rk_out_ready = 1;
    b8.rk_out_ready = 1;
`endif
    repeat (2) tick();
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_kv", b8.key_valid, 0);
    chk("rst_rk", b8.round_key, 0);
    rst = 1;
    tick();
    chk("idle_busy", b4.busy, 0);

    // all three widths expand concurrently
    b4.key_in = K4A; b6.key_in = K6; b8.key_in = K8;
    b4.start = 1; b6.start = 1; b8.start = 1;
    tick();
    b4.start = 0; b6.start = 0; b8.start = 0;
    chk("busy_after_start", b4.busy, 1);
    chk("kv_after_start", b4.key_valid, 0);
    d4 = 0; d6 = 0; d8 = 0; p4 = 0; p6 = 0; p8 = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) b6.key_in = '0;
      if (k == 11) b4.start = 0;
      tick();
      if (k == 10) begin
        b4.start = 1;
        b4.key_in = K4C;
      end
      if (k == 20) begin
        chk("rk_zero_busy", b8.round_key, 0);
        chk("busy_mid", b8.busy, 1);
      end
      if (b4.done) begin p4++; if (d4 == 0) d4 = k; end
      if (b6.done) begin p6++; if (d6 == 0) d6 = k; end
      if (b8.done) begin p8++; if (d8 == 0) d8 = k; end
    end
    chk("lat4", d4, 40);
    chk("lat6", d6, 46);
    chk("lat8", d8, 52);
    chk("pulses4", p4, 1);
    chk("pulses6", p6, 1);
    chk("pulses8", p8, 1);
    chk("kv4", b4.key_valid, 1);
    chk("busy8_done", b8.busy, 0);

    b4.rk_idx = 4'd10; b6.rk_idx = 4'd12; b8.rk_idx = 4'd14;
    tick();
    chk("nk4_r10", b4.round_key, R4A10);
    chk("nk6_r12", b6.round_key, R6_12);
    chk("nk8_r14", b8.round_key, R8_14);
    b4.rk_idx = 4'd0; b6.rk_idx = 4'd0; b8.rk_idx = 4'd0;
    tick();
    chk("nk4_r0", b4.round_key, K4A);
    chk("nk6_r0", b6.round_key, K6[191:64]);
    chk("nk8_r0", b8.round_key, K8[255:128]);
    b4.rk_idx = 4'd1; b6.rk_idx = 4'd1; b8.rk_idx = 4'd1;
    tick();
    chk("nk4_r1", b4.round_key, R4A1);
    chk("nk6_r1", b6.round_key, R6_1);
    chk("nk8_r1", b8.round_key, K8[127:0]);
    b4.rk_idx = 4'd11; b6.rk_idx = 4'd13; b8.rk_idx = 4'd15;
    tick();
    chk("nk4_oob", b4.round_key, 0);
    chk("nk6_oob", b6.round_key, 0);
    chk("nk8_oob", b8.round_key, 0);

    // restart from READY with a new key
    b4.key_in = K4C;
    b4.rk_idx = 4'd10;
    b4.start = 1;
    tick();
    b4.start = 0;
    chk("restart_kv", b4.key_valid, 0);
    chk("restart_busy", b4.busy, 1);
    chk("restart_rk", b4.round_key, 0);
    d4 = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (b4.done) begin d4 = k; break; end
    end
    chk("restart_lat", d4, 40);
    chk("restart_kv_up", b4.key_valid, 1);
    tick();
    chk("restart_r10", b4.round_key, R4C10);
    b4.rk_idx = 4'd0;
    tick();
    chk("restart_r0", b4.round_key, K4C);

    // reset during expansion
    b8.rk_idx = 4'd14;
    b8.start = 1;
    tick();
    b8.start = 0;
    repeat (19) tick();
    @(posedge clk);
    #1 rst = 0;
    #2;
    chk("arst_busy", b8.busy, 0);
    chk("arst_done", b8.done, 0);
    chk("arst_kv", b8.key_valid, 0);
    chk("arst_rk", b8.round_key, 0);
    chk("arst_rk4", b4.round_key, 0);
    @(negedge clk);
    rst = 1;
    p8 = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (b8.done) p8++;
    end
    chk("arst_no_done", p8, 0);
    chk("arst_kv_stays", b8.key_valid, 0);
    b8.start = 1;
    tick();
    b8.start = 0;
    d8 = 0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (b8.done) begin d8 = k; break; end
    end
    chk("post_rst_lat", d8, 52);
    tick();
    chk("post_rst_r14", b8.round_key, R8_14);

`ifdef KSCHED_STREAM_EN
    b4.key_in = K4A;
    b4.rk_out_ready = 0;
    b4.start = 1;
    tick();
    b4.start = 0;
    d4 = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (b4.done) begin d4 = k; break; end
    end
    chk("strm_lat", d4, 40);
    xfers = 0;
    exp_r = 10;
    hold = 0;
    pd = '0;
    pr = '0;
    for (int c = 0; c < 80; c++) begin
      b4.rk_out_ready = (c % 3 == 0);
      if (hold) begin
        chk("strm_stable_d", b4.rk_out, pd);
        chk("strm_stable_r", b4.rk_out_round, pr);
      end
      hold = b4.rk_out_valid && !b4.rk_out_ready;
      pd = b4.rk_out;
      pr = b4.rk_out_round;
      if (b4.rk_out_valid && b4.rk_out_ready) begin
        chk("strm_round", b4.rk_out_round, exp_r);
        if (exp_r == 10) chk("strm_r10", b4.rk_out, R4A10);
        if (exp_r == 0) chk("strm_r0", b4.rk_out, K4A);
        exp_r--;
        xfers++;
      end
      tick();
    end
    chk("strm_xfers", xfers, 11);
    chk("strm_idle", b4.rk_out_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_seq.md
Name: aes_key_schedule_seq

Overview:
- Iterative AES key-expansion engine that sits directly upstream of the decrypt round datapath.
- Takes the cipher key once it has been delivered over SPI and generates one 32-bit schedule word per clock into an internal word store.
- Serves any 128-bit round key by index with registered 1-cycle latency, so the decrypt core can walk rounds Nr..0.
- Replaces three parallel combinational expanders with a single shared SubWord path.

Parameters:
- Nk, 8: key length in 32-bit words; legal values 4/6/8, any other value is an elaboration error.
- Nr, 14: number of rounds; must equal Nk+6.
- Nb, 4: state width in words; fixed at 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- key_in  in  Nk*32  cipher key; w[0] is bits [Nk*32-1 -: 32].
- start  in  1  one-cycle request to expand key_in.
- busy  out  1  high while expansion is in progress.
- done  out  1  one-cycle pulse when the schedule is complete.
- key_valid  out  1  high while the stored schedule is complete and usable.
- rk_idx  in  4  round-key index, 0..Nr.
- round_key  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = rk_idx, registered.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy=0, done=0, key_valid=0, round_key=0, word index i=0, rcon=8'h01. The word store is not required to be cleared.
- TOTAL = Nb*(Nr+1), giving 44, 52 or 60 words.
- States:
  - IDLE: start=1 at an edge loads w[0..Nk-1] from key_in, sets i=Nk and rcon=01, goes to EXPAND, busy=1, key_valid=0.
  - EXPAND: each edge computes one word:
    - temp = w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (sequence 01,02,04,08,10,20,40,80,1B,36).
    - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
    - w[i] = w[i-Nk] ^ temp; i = i+1.
    - After writing w[TOTAL-1], go to READY.
  - READY: busy=0, key_valid=1; done is high for exactly the first cycle in READY.
- Latency: done is asserted after edge number TOTAL-Nk counted from the start edge, i.e. 40, 46 or 52 for Nk = 4, 6, 8.
- start during EXPAND is ignored.
- start in READY restarts expansion: key_valid drops on that edge and the new key_in is loaded.
- key_in is sampled only on the start edge; later changes have no effect on the schedule.
- Read port:
  - round_key updates on every edge from rk_idx. It is meaningful only while key_valid=1.
  - rk_idx > Nr yields round_key = 0.
  - While not key_valid, round_key holds 0.
- Reset asserted mid-EXPAND aborts immediately; the next run requires a fresh start.

Optional Feature:
- Macro: KSCHED_STREAM_EN.
- When defined, adds ports:
  - rk_out (out, 128)
  - rk_out_valid (out, 1)
  - rk_out_ready (in, 1)
  - rk_out_round (out, 4)
- Streaming behaviour:
  - On entering READY, streams round keys in decrypt order Nr, Nr-1, ..., 0.
  - Transfer on valid&&ready; valid holds and data is stable until accepted.
  - After round 0 is accepted, valid deasserts.
  - A restart or reset flushes the stream.
- When not defined, these ports and their logic are absent; the indexed read port is unaffected either way.

Decomposition:
- Shared package aes_pkg holds:
  - the S-box constant table;
  - an xtime function;
  - the RCON first value;
  - the state enum (IDLE, EXPAND, READY);
  - localparam helpers TOTAL_WORDS(Nk) and NR_OF(Nk).
- One sub-module aes_sub_word: 32-bit in/out, four parallel S-box lookups, combinational. It is instantiated once in the expansion datapath.

Test Plan:
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> done after 40 edges; rk_idx=10 gives round_key d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=0 gives the key itself.
- Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 edges; rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 edges; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
- start re-pulsed mid-EXPAND and key_in changed -> ignored; results identical to the undisturbed run. start in READY with a new key -> key_valid falls on that edge, rises with the new schedule.
- rst driven low at edge 20 of expansion -> busy, done, key_valid and round_key are 0 asynchronously; no done pulse; a subsequent start produces a correct schedule.
- KSCHED_STREAM_EN, Nk=4, ready toggled 1,0,0,1,... -> 11 transfers with rk_out_round 10..0 in order, data stable while stalled, round 10 key as above.
